// File: rtl/sprite_loader_pkg.sv
// Shared types and constants for the sprite write-side loader.
package sprite_pkg;

  localparam int SPRITE_DEPTH  = 1024;
  localparam int SPRITE_ADDR_W = 10;
  localparam int PIXEL_W       = 9;

  typedef enum logic [2:0] {
    IDLE,
    LO,
    HI,
    WR,
    DONE
  } state_t;

  // RGB333 pixel: bit 8 comes from the high byte, bits 7:0 from the low byte.
  function automatic logic [PIXEL_W-1:0] pack_pixel(input logic [7:0] lo, input logic [7:0] hi);
    return {hi[0], lo};
  endfunction

endpackage

// File: rtl/sprite_loader_packer.sv
// Captures a low/high byte pair, packs it into one pixel and flags malformed high bytes.
module byte_pair_packer
  import sprite_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               take_lo,
  input  logic               take_hi,
  input  logic [7:0]         data_byte,
  output logic [PIXEL_W-1:0] pixel,
  output logic               pixel_valid,
  output logic               fmt_err
);

  logic [7:0] lo_byte;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lo_byte     <= 8'd0;
      pixel       <= '0;
      pixel_valid <= 1'b0;
      fmt_err     <= 1'b0;
    end else begin
      pixel_valid <= take_hi;
      if (take_lo) lo_byte <= data_byte;
      // pixel holds its value between pairs so the write data stays stable
      if (take_hi) pixel <= pack_pixel(lo_byte, data_byte);
      if (clear) fmt_err <= 1'b0;
      else if (take_hi && (data_byte[7:1] != 7'd0)) fmt_err <= 1'b1;
    end
  end

endmodule

// File: rtl/sprite_loader.sv
// Byte-stream to sprite-memory write port loader. Optional checksum output is
// enabled with the SPRITE_LOADER_CHECKSUM_EN macro.
module sprite_loader #(
  parameter int DEPTH   = sprite_pkg::SPRITE_DEPTH,
  parameter int ADDR_W  = sprite_pkg::SPRITE_ADDR_W,
  parameter int PIXEL_W = sprite_pkg::PIXEL_W
) (
  input  logic               i_Clk,
  input  logic               i_Rst_N,
  input  logic               i_Start,
  input  logic [7:0]         i_Byte,
  input  logic               i_Byte_Valid,
  output logic               o_Byte_Ready,
  output logic               o_Wr_En,
  output logic [ADDR_W-1:0]  o_Wr_Addr,
  output logic [PIXEL_W-1:0] o_Wr_Data,
  output logic               o_Busy,
  output logic               o_Done,
  output logic               o_Fmt_Err,
`ifdef SPRITE_LOADER_CHECKSUM_EN
  output logic [7:0]         o_Checksum,
`endif
  output logic [2:0]         o_State
);
  import sprite_pkg::*;

  // Handshake: a byte moves on a rising edge where i_Byte_Valid && o_Byte_Ready;
  // ready depends only on state, valid may rise without waiting for ready.

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] count;
  logic              take_lo;
  logic              take_hi;
  logic              start_ok;
  logic              last_pixel;

  assign o_Byte_Ready = (state == LO) || (state == HI);
  assign take_lo      = (state == LO) && i_Byte_Valid;
  assign take_hi      = (state == HI) && i_Byte_Valid;
  assign start_ok     = i_Start && ((state == IDLE) || (state == DONE));
  assign last_pixel   = (count == ADDR_W'(DEPTH - 1));
  assign o_Busy       = (state == LO) || (state == HI) || (state == WR);
  assign o_Done       = (state == DONE);
  assign o_State      = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_Start) state_nxt = LO;
      LO:      if (i_Byte_Valid) state_nxt = HI;
      HI:      if (i_Byte_Valid) state_nxt = WR;
      WR:      state_nxt = last_pixel ? DONE : LO;
      DONE:    if (i_Start) state_nxt = LO;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N) begin
      state     <= IDLE;
      count     <= '0;
      o_Wr_Addr <= '0;
    end else begin
      state <= state_nxt;
      if (start_ok) count <= '0;
      else if ((state == WR) && !last_pixel) count <= count + 1'b1;
      // address registered alongside the pixel so both line up with the strobe
      if (take_hi) o_Wr_Addr <= count;
    end
  end

  byte_pair_packer u_packer (
    .clk         (i_Clk),
    .rst_n       (i_Rst_N),
    .clear       (start_ok),
    .take_lo     (take_lo),
    .take_hi     (take_hi),
    .data_byte   (i_Byte),
    .pixel       (o_Wr_Data),
    .pixel_valid (o_Wr_En),
    .fmt_err     (o_Fmt_Err)
  );

`ifdef SPRITE_LOADER_CHECKSUM_EN
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_N || start_ok) o_Checksum <= 8'd0;
    else if (take_lo || take_hi) o_Checksum <= o_Checksum + i_Byte;
  end
`else
  // No byte accumulator in this build.
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// Directed-plus-random bench for sprite_loader against a byte-stream reference model.
`timescale 1ns/1ps
module tb_sprite_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] byte_in;
  logic       valid;
  logic       ready;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [8:0] wr_data;
  logic       busy;
  logic       done;
  logic       fmt_err;
  logic [2:0] state;
`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] checksum;
`endif

  int errors   = 0;
  int checks   = 0;
  int cycle    = 0;
  int timeouts = 0;

  logic [7:0]  stream[$];
  logic [18:0] exp_q[$];
  logic [18:0] obs_q[$];
  int          obs_cyc_q[$];
  logic        exp_fmt;
  logic [7:0]  exp_sum;

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  initial begin
    #900_000;
    $display("FAIL watchdog observed=time_limit expected=finish");
    $fatal(1, "watchdog");
  end

  sprite_loader dut (
    .i_Clk        (clk),
    .i_Rst_N      (rst_n),
    .i_Start      (start),
    .i_Byte       (byte_in),
    .i_Byte_Valid (valid),
    .o_Byte_Ready (ready),
    .o_Wr_En      (wr_en),
    .o_Wr_Addr    (wr_addr),
    .o_Wr_Data    (wr_data),
    .o_Busy       (busy),
    .o_Done       (done),
    .o_Fmt_Err    (fmt_err),
`ifdef SPRITE_LOADER_CHECKSUM_EN
    .o_Checksum   (checksum),
`endif
    .o_State      (state)
  );

  // write-port monitor: record every write, and a write must never overlap byte acceptance
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_cyc_q.push_back(cycle);
      checks++;
      assert (ready === 1'b0)
        else begin errors++; $error("FAIL wr_while_ready observed=%b expected=0", ready); end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin errors++; $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp); end
  endtask

  // reference model: byte pairs become pixels at consecutive addresses, capped at 1024
  task automatic build_model();
    exp_q.delete();
    exp_fmt = 1'b0;
    exp_sum = 8'd0;
    for (int i = 0; i < stream.size(); i++) exp_sum = exp_sum + stream[i];
    for (int p = 0; p < stream.size() / 2 && p < 1024; p++) begin
      logic [7:0] lo;
      logic [7:0] hi;
      lo = stream[2*p];
      hi = stream[2*p+1];
      exp_q.push_back({10'(p), hi[0], lo});
      if (hi[7:1] != 7'd0) exp_fmt = 1'b1;
    end
  endtask

  function automatic logic prefix_fmt(input int npix);
    logic f;
    logic [7:0] hi;
    f = 1'b0;
    for (int p = 0; p < npix; p++) begin
      hi = stream[2*p+1];
      if (hi[7:1] != 7'd0) f = 1'b1;
    end
    return f;
  endfunction

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int t;
    while ($urandom_range(99, 0) < gap_pct) begin
      valid   = 1'b0;
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    valid   = 1'b1;
    byte_in = b;
    t = 0;
    while (ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      checks++;
      errors++;
      timeouts++;
      $error("FAIL accept_timeout observed=ready_low expected=ready_high");
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_start();
    obs_q.delete();
    obs_cyc_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_done_low", done, 0);
    check("start_busy_high", busy, 1);
    check("start_fmt_clear", fmt_err, 0);
  endtask

  task automatic run_stream(input int gap_pct, input int start_at, input int probe0, input int probe1);
    for (int i = 0; i < stream.size(); i++) begin
      if (timeouts > 3) break;
      if (i == 2*start_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (i == 2*probe0 || i == 2*probe1)
        check($sformatf("fmt_prefix_%0d", i/2), fmt_err, prefix_fmt(i/2));
      send_byte(stream[i], gap_pct);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", done, 1);
    check("done_busy_low", busy, 0);
    check("done_ready_low", ready, 0);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_wr%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  initial begin
    int bad;
    int seen;
    rst_n   = 1'b0;
    start   = 1'b0;
    valid   = 1'b0;
    byte_in = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state, and IDLE must not accept bytes
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_fmt_err", fmt_err, 0);
    valid = 1'b1;
    byte_in = 8'hAA;
    seen = 0;
    repeat (4) begin
      if (ready !== 1'b0) seen++;
      @(negedge clk);
    end
    valid = 1'b0;
    check("idle_ready_low", seen, 0);

    // A: counting stream, valid always high
    stream.delete();
    for (int k = 0; k < 1024; k++) begin
      stream.push_back(k[7:0]);
      stream.push_back({7'd0, k[8]});
    end
    build_model();
    do_start();
    run_stream(0, -1, -1, -1);
    wait_done();
    check_writes("seq");
    bad = 0;
    for (int i = 1; i < obs_cyc_q.size(); i++)
      if (obs_cyc_q[i] - obs_cyc_q[i-1] != 3) bad++;
    check("seq_spacing", bad, 0);
    check("seq_fmt", fmt_err, exp_fmt);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    check("seq_checksum", checksum, exp_sum);
`endif

    // B: random pixels with ~50% valid gaps
    stream.delete();
    for (int k = 0; k < 1024; k++) begin
      stream.push_back(8'($urandom));
      stream.push_back({7'd0, 1'($urandom_range(1, 0))});
    end
    build_model();
    do_start();
    run_stream(50, -1, -1, -1);
    wait_done();
    check_writes("gap");

    // C: malformed high byte at pixel 5, ignored start at pixel 100
    stream.delete();
    for (int k = 0; k < 1024; k++) begin
      stream.push_back(8'($urandom));
      stream.push_back((k == 5) ? 8'h03 : {7'd0, 1'($urandom_range(1, 0))});
    end
    build_model();
    do_start();
    run_stream(30, 100, 5, 6);
    wait_done();
    check_writes("fmt");
    check("fmt_sticky_end", fmt_err, exp_fmt);

    // D: reset coincident with the high byte of pixel 7
    stream.delete();
    for (int k = 0; k < 7; k++) begin
      stream.push_back(8'($urandom_range(255, 1)));
      stream.push_back(8'h01);
    end
    build_model();
    stream.push_back(8'h5A);
    do_start();
    run_stream(0, -1, -1, -1);
    valid   = 1'b1;
    byte_in = 8'h01;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_wr_en", wr_en, 0);
    check("mid_rst_wr_addr", wr_addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    seen = 0;
    repeat (5) begin
      if (ready !== 1'b0) seen++;
      @(negedge clk);
    end
    valid = 1'b0;
    check("mid_rst_ready_low", seen, 0);
    check_writes("mid_rst");

    // E: all-ones stream, then one low byte altered
    stream.delete();
    for (int k = 0; k < 2048; k++) stream.push_back(8'h01);
    build_model();
    do_start();
    run_stream(0, -1, -1, -1);
    wait_done();
    check_writes("ones");
`ifdef SPRITE_LOADER_CHECKSUM_EN
    check("ones_checksum", checksum, exp_sum);
`endif
    stream[2046] = 8'h05;
    build_model();
    do_start();
    run_stream(0, -1, -1, -1);
    wait_done();
    check_writes("ones5");
`ifdef SPRITE_LOADER_CHECKSUM_EN
    check("ones5_checksum", checksum, exp_sum);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
